parallel_serial_converter: RTL and testbench
============================================

// Module: parallel_serial_converter
// PURPOSE
// - Transmit-side counterpart of the switch ingress serial->parallel path: pops wide words plus
//   frame info from an egress FIFO (FWFT) and emits them lane by lane on a narrow serial port.
// - Sits between the switch egress buffer and the port MAC; lane 0 = data[serialWidth-1:0] goes first.
// - Supports output backpressure; back-to-back words with no bubble.
// PARAMETERS
// - parallelWidth  512  width of popped word; must be a multiple of serialWidth
// - serialWidth    8    width of one serial beat
// - (localparam) lanes = parallelWidth/serialWidth; LW = $clog2(lanes); LENW = $clog2(parallelWidth)+1
// PORTS
// - clk               in   1              single clock
// - rst               in   1              reset, asynchronous, active-high
// - inEmpty           in   1              source FIFO empty; when 0 the in* fields are valid (FWFT)
// - inPop             out  1              pop/consume current FIFO word (one-cycle pulse)
// - inData            in   parallelWidth  word to serialise
// - inDataPresent     in   1              0 = filler word, popped and discarded
// - inStartOfFrame    in   1              word holds first beat of a frame
// - inLength          in   LENW           index of last valid lane (valid beats - 1)
// - inEndOfFrame      in   1              word holds last beat of a frame
// - inError           in   1              frame error flag for this word
// - outValid          out  1              outData/flags valid this cycle
// - outReady          in   1              sink accepts beat when outValid&&outReady
// - outData           out  serialWidth    serial beat
// - outStartOfFrame   out  1              first beat of frame
// - outEndOfFrame     out  1              last beat of frame
// - outError          out  1              error, held on every beat of an errored word
// - busy              out  1              a word is loaded and not yet fully sent
// BEHAVIOUR
// - Reset: all registers cleared; outValid=0, outData=0, all out flags=0, inPop=0, busy=0, state IDLE.
// - State IDLE: if !inEmpty -> inPop=1 that cycle; if inDataPresent capture word, info, lane=0,
//   go SEND; else discard and stay IDLE. inPop is combinational from state/inEmpty/outReady.
// - State SEND: outValid=1; outData = word[lane*serialWidth +: serialWidth] (registered word, mux lane).
//   - outStartOfFrame = sof && lane==0; outEndOfFrame = eof && lane==lastLane; outError = err.
//   - outReady=0: all outputs held stable (AXI-style; no retraction of valid).
//   - outReady=1 and lane<lastLane: lane+1.
//   - outReady=1 and lane==lastLane: word done; if !inEmpty pop and load next word in the same cycle
//     (zero-bubble; filler word -> go IDLE), else go IDLE.
// - First beat appears the cycle after the pop (latency 1); throughput 1 beat/clk under outReady=1.
// - lastLane = min(inLength, lanes-1) captured at load; oversize length clamps, never wraps lane.
// - inLength=0 -> single-beat word; sof and eof may both assert on the same beat.
// - inPop never asserted while inEmpty=1.
// - rst mid-word: in-flight word dropped, no partial beats after release, returns to IDLE.
// - busy = (state==SEND).
// STRUCTURE
// - Reuse info_type from genericSwitchPkg (dataPresent, startOfFrame, length, endOfFrame, error) for
//   the captured info register; add state enum typedef psc_state_t {IDLE, SEND} to the package.
// - Single module, no sub-modules; lane select is an indexed part-select.
// - Simulation-only check: display an error if inPop && inEmpty.
// TESTING (parallelWidth=32, serialWidth=8, lanes=4)
// - Full word 0x44332211, sof=1,eof=0,len=3, outReady=1 -> beats 11,22,33,44; sof on 11; 1 pop.
// - Two words queued (len=3, then len=1 eof=1 data 0x....BBAA) -> 6 beats back-to-back, no gap;
//   eof only on AA..BB's BB beat.
// - outReady toggled 1,0,0,1,... -> each beat held stable while stalled; no beat lost or duplicated.
// - inDataPresent=0 word then valid len=0 sof=eof=err=1 word 0x000000EE -> filler dropped silently;
//   single beat EE with sof, eof, error all high.
// - inLength=7 (oversize) -> exactly 4 beats emitted, then IDLE.
// - rst asserted after beat 2 of 4 -> outValid=0 immediately, busy=0; after release next FIFO word
//   starts at lane 0.

Source files
------------

// File: rtl/parallel_serial_converter_pkg.sv
// Shared types for the egress parallel->serial converter: captured frame info and FSM state.
package parallel_serial_converter_pkg;

  // Wide enough for the clamped last-lane index of any practical word/beat ratio.
  localparam int INFO_LENW = 16;

  // Frame info captured alongside each loaded word.
  typedef struct packed {
    logic                 dataPresent;
    logic                 startOfFrame;
    logic [INFO_LENW-1:0] length;       // index of last lane to send (already clamped)
    logic                 endOfFrame;
    logic                 error;
  } info_type;

  typedef enum logic {IDLE, SEND} psc_state_t;

endpackage

// File: rtl/parallel_serial_converter.sv
// Pops wide words from an FWFT egress FIFO and emits them lane by lane (lane 0 first)
// on a narrow ready/valid serial port, back-to-back with no bubble between words.
module parallel_serial_converter
  import parallel_serial_converter_pkg::*;
#(
  parameter int parallelWidth = 512,
  parameter int serialWidth   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               inEmpty,
  output logic                               inPop,
  input  logic [parallelWidth-1:0]           inData,
  input  logic                               inDataPresent,
  input  logic                               inStartOfFrame,
  input  logic [$clog2(parallelWidth):0]     inLength,
  input  logic                               inEndOfFrame,
  input  logic                               inError,
  output logic                               outValid,
  input  logic                               outReady,
  output logic [serialWidth-1:0]             outData,
  output logic                               outStartOfFrame,
  output logic                               outEndOfFrame,
  output logic                               outError,
  output logic                               busy
);

  localparam int lanes = parallelWidth / serialWidth;
  localparam int LW    = $clog2(lanes);
  localparam int LENW  = $clog2(parallelWidth) + 1;

  psc_state_t               state;
  logic [parallelWidth-1:0] word;
  info_type                 info;
  logic [LW-1:0]            lane;

  logic                     lastBeat;
  logic [LENW-1:0]          clampLen;
  info_type                 loadInfo;

  // Oversize lengths clamp to the top lane so the lane counter never wraps.
  always_comb begin
    clampLen = (inLength > LENW'(lanes - 1)) ? LENW'(lanes - 1) : inLength;
    loadInfo = '{dataPresent:  1'b1,
                 startOfFrame: inStartOfFrame,
                 length:       INFO_LENW'(clampLen),
                 endOfFrame:   inEndOfFrame,
                 error:        inError};
  end

  assign lastBeat = (INFO_LENW'(lane) == info.length);

  // Pop when idle, or when the final beat of the current word is being accepted (zero bubble).
  assign inPop = !rst && !inEmpty && ((state == IDLE) || (outReady && lastBeat));

  // Output beat is a lane mux over the registered word; held stable while stalled.
  assign outValid        = (state == SEND) && info.dataPresent;
  assign outData         = word[lane*serialWidth +: serialWidth];
  assign outStartOfFrame = outValid && info.startOfFrame && (lane == '0);
  assign outEndOfFrame   = outValid && info.endOfFrame && lastBeat;
  assign outError        = outValid && info.error;
  assign busy            = (state == SEND);

  // Load/advance FSM: filler words are consumed by the pop and never loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word  <= '0;
      info  <= '0;
      lane  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inPop && inDataPresent) begin
            word  <= inData;
            info  <= loadInfo;
            lane  <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (outReady) begin
            if (!lastBeat) begin
              lane <= lane + 1'b1;
            end else if (inPop && inDataPresent) begin
              word <= inData;
              info <= loadInfo;
              lane <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Simulation-only guard: a pop must never be issued against an empty FIFO.
  always @(posedge clk) begin
    if (!rst) assert (!(inPop && inEmpty));
  end

endmodule

// File: tb/tb_parallel_serial_converter.sv
// Directed + randomized bench: an FWFT FIFO model feeds the DUT, and each popped word
// is expanded into its expected beats, which are checked as the sink accepts them.
module tb_parallel_serial_converter;

  localparam int PW = 32, SW = 8, LANES = 4, LENW = 6;

  logic clk = 1'b0, rst = 1'b1;
  logic inEmpty, inPop, inDataPresent, inStartOfFrame, inEndOfFrame, inError;
  logic [PW-1:0] inData;
  logic [LENW-1:0] inLength;
  logic outValid, outReady, outStartOfFrame, outEndOfFrame, outError, busy;
  logic [SW-1:0] outData;

  always #5 clk = ~clk;

  parallel_serial_converter #(.parallelWidth(PW), .serialWidth(SW)) dut (
    .clk(clk), .rst(rst), .inEmpty(inEmpty), .inPop(inPop), .inData(inData),
    .inDataPresent(inDataPresent), .inStartOfFrame(inStartOfFrame), .inLength(inLength),
    .inEndOfFrame(inEndOfFrame), .inError(inError), .outValid(outValid), .outReady(outReady),
    .outData(outData), .outStartOfFrame(outStartOfFrame), .outEndOfFrame(outEndOfFrame),
    .outError(outError), .busy(busy));

  typedef struct { logic [PW-1:0] d; bit dp, sof, eof, err; logic [LENW-1:0] len; } word_t;
  typedef struct { logic [SW-1:0] d; bit sof, eof, err; } beat_t;

  word_t fifo[$];
  beat_t expq[$];
  int nAsserts = 0, nFail = 0;
  int popCount, beatCount, eofCount, cyc = 0, firstBeat, lastBeatCyc, popCyc;
  bit holdValid = 0;
  beat_t held;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(logic [PW-1:0] d, bit dp, bit sof, bit eof, bit err, logic [LENW-1:0] len);
    fifo.push_back('{d:d, dp:dp, sof:sof, eof:eof, err:err, len:len});
  endtask

  task automatic drive();
    if (fifo.size() > 0) begin
      inEmpty = 0; inData = fifo[0].d; inDataPresent = fifo[0].dp;
      inStartOfFrame = fifo[0].sof; inEndOfFrame = fifo[0].eof;
      inError = fifo[0].err; inLength = fifo[0].len;
    end else begin
      inEmpty = 1; inData = '0; inDataPresent = 0; inStartOfFrame = 0;
      inEndOfFrame = 0; inError = 0; inLength = '0;
    end
  endtask

  // Reference: a present word yields min(len, LANES-1)+1 beats, lane 0 first.
  task automatic expand(word_t w);
    int n;
    logic [PW-1:0] t;
    if (!w.dp) return;
    n = (int'(w.len) > LANES - 1) ? LANES : int'(w.len) + 1;
    for (int i = 0; i < n; i++) begin
      t = w.d >> (SW * i);
      expq.push_back('{d:t[SW-1:0], sof:(w.sof && i == 0), eof:(w.eof && i == n - 1), err:w.err});
    end
  endtask

  task automatic resetCounters();
    popCount = 0; beatCount = 0; eofCount = 0; firstBeat = -1; lastBeatCyc = -1; popCyc = -1;
  endtask

  // One clock: sample at negedge, apply FIFO pop just after the posedge.
  task automatic cycle(bit rdy);
    bit p;
    beat_t e;
    outReady = rdy;
    @(negedge clk);
    check("valid_vs_model", outValid, expq.size() > 0);
    check("busy_vs_model", busy, expq.size() > 0);
    check("pop_on_empty", inPop && inEmpty, 0);
    if (holdValid) begin
      check("stall_valid", outValid, 1);
      check("stall_data", outData, held.d);
      check("stall_sof", outStartOfFrame, held.sof);
      check("stall_eof", outEndOfFrame, held.eof);
      check("stall_err", outError, held.err);
    end
    holdValid = outValid && !outReady;
    held = '{d:outData, sof:outStartOfFrame, eof:outEndOfFrame, err:outError};
    if (outValid && outReady && expq.size() > 0) begin
      e = expq.pop_front();
      check("beat_data", outData, e.d);
      check("beat_sof", outStartOfFrame, e.sof);
      check("beat_eof", outEndOfFrame, e.eof);
      check("beat_err", outError, e.err);
      beatCount++;
      if (e.eof) eofCount++;
      if (firstBeat < 0) firstBeat = cyc;
      lastBeatCyc = cyc;
    end
    p = inPop;
    @(posedge clk); #1;
    cyc++;
    if (p && fifo.size() > 0) begin
      popCount++;
      if (popCyc < 0) popCyc = cyc;
      expand(fifo.pop_front());
    end
    drive();
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0; 2: random ready.
  task automatic drain(int mode, int budget);
    int n = 0;
    bit r;
    while ((fifo.size() > 0 || expq.size() > 0 || busy) && n < budget) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 3 == 0) : 1'($urandom_range(0, 1));
      cycle(r);
      n++;
    end
    check("drain_timeout", fifo.size() + expq.size(), 0);
    check("idle_after_drain", busy, 0);
  endtask

  initial begin
    int guard;
    outReady = 1;
    drive();
    // Reset state, including no pop while in reset even with a word waiting.
    #12;
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 0);
    check("rst_flags", {outStartOfFrame, outEndOfFrame, outError}, 0);
    check("rst_busy", busy, 0);
    push(32'h44332211, 1, 1, 0, 0, 3);
    drive();
    #1;
    check("rst_no_pop", inPop, 0);
    @(posedge clk); #1;
    rst = 0;

    // Full word, single pop, first beat one cycle after the pop.
    resetCounters();
    drain(0, 50);
    check("t1_beats", beatCount, 4);
    check("t1_pops", popCount, 1);
    check("t1_latency", firstBeat, popCyc);

    // Two words back-to-back, no gap between them.
    resetCounters();
    push(32'hDDCCBBAA ^ 32'h11000000, 1, 1, 0, 0, 3);
    push(32'h0000BBAA, 1, 0, 1, 0, 1);
    drive();
    drain(0, 50);
    check("t2_beats", beatCount, 6);
    check("t2_span", lastBeatCyc - firstBeat, 5);
    check("t2_eofs", eofCount, 1);

    // Stalls with ready pattern 1,0,0: beats held, none lost or duplicated.
    resetCounters();
    for (int i = 0; i < 4; i++) push($urandom, 1, 1, 1, 1'($urandom_range(0, 1)), 3);
    drive();
    drain(1, 200);
    check("t3_beats", beatCount, 16);

    // Filler dropped, then single-beat word with sof/eof/err together.
    resetCounters();
    push($urandom, 0, 1, 1, 1, 3);
    push(32'h000000EE, 1, 1, 1, 1, 0);
    drive();
    drain(0, 50);
    check("t4_beats", beatCount, 1);
    check("t4_pops", popCount, 2);

    // Oversize length clamps to four beats.
    resetCounters();
    push(32'hCAFEF00D, 1, 1, 1, 0, 7);
    drive();
    drain(0, 50);
    check("t5_beats", beatCount, 4);

    // Random words, lengths and backpressure.
    resetCounters();
    for (int i = 0; i < 40; i++)
      push($urandom, 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           (i == 7) ? LENW'(63) : LENW'($urandom_range(0, 7)));
    drive();
    drain(2, 3000);

    // Reset after two beats of a four-beat word; next word restarts at lane 0.
    resetCounters();
    push(32'hA4A3A2A1, 1, 1, 0, 0, 3);
    push(32'hB4B3B2B1, 1, 1, 1, 0, 3);
    drive();
    guard = 0;
    while (beatCount < 2 && guard < 20) begin cycle(1); guard++; end
    check("t6_reach_beat2", beatCount, 2);
    rst = 1;
    #1;
    check("t6_rst_valid", outValid, 0);
    check("t6_rst_busy", busy, 0);
    expq.delete();
    holdValid = 0;
    cycle(1);
    cycle(1);
    rst = 0;
    resetCounters();
    drain(0, 50);
    check("t6_beats_after", beatCount, 4);
    check("t6_pops_after", popCount, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
